// File: rtl/iob_fifo2stream_pkg.sv
// Shared types and constants for the FIFO-to-stream read adapter.
package iob_fifo2stream_pkg;

    localparam int unsigned BufDepth = 2;

    // Encoding doubles as the number of buffered words.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

    function automatic logic [1:0] buf_count(input buf_state_e st);
        return st;
    endfunction

endpackage

// File: rtl/iob_fifo2stream_buf.sv
// Two-entry ordered output buffer: arrivals queue behind the head, head is the stream word.
module iob_fifo2stream_buf
    import iob_fifo2stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output buf_state_e        state,
    output logic [DATA_W-1:0] head
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clear) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_d  = push_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_d = push_data;
                    end else if (push) begin
                        tail_d  = push_data;
                        state_d = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // A push without a pop here is prevented by the issue logic upstream.
                    if (pop) begin
                        head_d = tail_q;
                        if (push) begin
                            tail_d = push_data;
                        end else begin
                            state_d = StOne;
                        end
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign state = state_q;
    assign head  = head_q;

endmodule

// File: rtl/iob_fifo2stream.sv
// Drains a FIFO read port into a valid/ready stream, hiding the one-cycle read latency.
// Optional packet framing (m_last) is built when IOB_FIFO2STREAM_LAST_EN is defined.
module iob_fifo2stream
    import iob_fifo2stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
`ifdef IOB_FIFO2STREAM_LAST_EN
    output logic              m_last,
`endif
    input  logic              m_ready
);

    buf_state_e buf_state;
    logic [1:0] count;
    logic [2:0] occ;
    logic       pop;
    logic       inflight_q;

    iob_fifo2stream_buf #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (inflight_q),
        .push_data(fifo_data),
        .pop      (pop),
        .state    (buf_state),
        .head     (m_data)
    );

    assign count   = buf_count(buf_state);
    assign m_valid = (buf_state != StEmpty);
    assign pop     = m_valid & m_ready;

    // Words held next cycle if no new read is issued now; pop implies count >= 1.
    assign occ = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

    // rst_n gating keeps the FIFO untouched while the adapter is held in reset.
    assign fifo_read_en = rst_n & ~fifo_empty & ~clear & (occ < 3'(BufDepth));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_read_en;
        end
    end

`ifdef IOB_FIFO2STREAM_LAST_EN
    localparam int unsigned    BeatW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

    logic [BeatW-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clear) begin
            beat_d = '0;
        end else if (pop) begin
            beat_d = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_last = m_valid & (beat_q == LastBeat);
`else
    logic unused_pkt_len;
    assign unused_pkt_len = ^PKT_LEN;
`endif

endmodule

// File: tb/tb_iob_fifo2stream.sv
// Scoreboard bench for iob_fifo2stream: directed FIFO loads, a behavioural FIFO and a stream monitor.
module tb_iob_fifo2stream;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PKT_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_read_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
`ifdef IOB_FIFO2STREAM_LAST_EN
    logic              m_last;
    int                mdl_beat = 0;
    int                lasts = 0;
`endif

    iob_fifo2stream #(
        .DATA_W (DATA_W),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
`ifdef IOB_FIFO2STREAM_LAST_EN
        .m_last      (m_last),
`endif
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int reads = 0;
    int beats = 0;

    logic [DATA_W-1:0] fifo_mem[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: registered read data, empty flag updates on the clock edge.
    always @(posedge clk) begin
        if (fifo_read_en && fifo_mem.size() > 0) begin
            fifo_data <= fifo_mem.pop_front();
        end
        fifo_empty <= (fifo_mem.size() == 0);
    end

    // Monitor: occupancy model plus in-order data scoreboard.
    int                mdl_cnt = 0;
    int                mdl_infl = 0;
    int                mdl_occ;
    logic              mdl_pop;
    logic              stalled = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic [DATA_W-1:0] exp_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < mdl_cnt + mdl_infl; i++) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            mdl_cnt  = 0;
            mdl_infl = 0;
            stalled  = 1'b0;
            check("reset_m_valid", 32'(m_valid), 32'd0);
            check("reset_m_data", 32'(m_data), 32'd0);
            check("reset_read_en", 32'(fifo_read_en), 32'd0);
`ifdef IOB_FIFO2STREAM_LAST_EN
            mdl_beat = 0;
            check("reset_m_last", 32'(m_last), 32'd0);
`endif
        end else begin
            check("m_valid", 32'(m_valid), 32'(mdl_cnt != 0));
            if (stalled) check("stall_hold", 32'(m_data), 32'(held_data));
`ifdef IOB_FIFO2STREAM_LAST_EN
            check("m_last", 32'(m_last), 32'((mdl_cnt != 0) && (mdl_beat == PKT_LEN - 1)));
`endif
            mdl_pop = (mdl_cnt != 0) && m_ready;
            if (mdl_pop) begin
                beats++;
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(exp_word));
                end
`ifdef IOB_FIFO2STREAM_LAST_EN
                if (m_last) lasts++;
                mdl_beat = (mdl_beat == PKT_LEN - 1) ? 0 : mdl_beat + 1;
`endif
            end
            mdl_occ = mdl_cnt + mdl_infl - int'(mdl_pop);
            check("occupancy_le_2", 32'(mdl_occ <= 2), 32'd1);
            check("read_gate", 32'(fifo_read_en && (fifo_empty || clear || mdl_occ >= 2)), 32'd0);
            if (fifo_read_en) reads++;
            if (clear) begin
                for (int i = 0; i < mdl_occ; i++) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                mdl_cnt  = 0;
                mdl_infl = 0;
`ifdef IOB_FIFO2STREAM_LAST_EN
                mdl_beat = 0;
`endif
            end else begin
                mdl_cnt  = mdl_occ;
                mdl_infl = int'(fifo_read_en);
            end
            stalled   = m_valid && !m_ready && !clear;
            held_data = m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(base + DATA_W'(i));
            exp_q.push_back(base + DATA_W'(i));
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(m_valid), 32'd1);
    endtask

    int r0, b0;

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single word: read in N, data in N+1, m_valid in N+2.
        r0 = reads; b0 = beats;
        m_ready = 1'b1;
        push_words(8'h11, 1);
        @(negedge clk);
        check("t1_no_early_read", 32'(fifo_read_en), 32'd0);
        @(negedge clk);
        check("t1_read_cycle_n", 32'(fifo_read_en), 32'd1);
        check("t1_invalid_n", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("t1_invalid_n1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_n2", 32'(m_valid), 32'd1);
        check("t1_data_n2", 32'(m_data), 32'h11);
        @(negedge clk);
        check("t1_drained", 32'(m_valid), 32'd0);
        tick(3);
        check("t1_read_pulses", 32'(reads - r0), 32'd1);
        check("t1_beats", 32'(beats - b0), 32'd1);

        // Eight words at full rate: no bubbles after the first beat.
        r0 = reads; b0 = beats;
        push_words(8'h00, 8);
        wait_valid("t2_first", 10);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("t2_no_bubble", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        check("t2_done", 32'(m_valid), 32'd0);
        tick(2);
        check("t2_read_pulses", 32'(reads - r0), 32'd8);
        check("t2_beats", 32'(beats - b0), 32'd8);

        // Back-pressure pattern 1,0,0,1.
        b0 = beats;
        push_words(8'h20, 6);
        for (int i = 0; i < 40; i++) begin
            m_ready = !((i % 4) == 1 || (i % 4) == 2);
            tick(1);
        end
        m_ready = 1'b1;
        tick(5);
        check("t3_beats", 32'(beats - b0), 32'd6);
        check("t3_all_delivered", 32'(exp_q.size()), 32'd0);

        // Clear with two words held and nothing in flight.
        m_ready = 1'b0;
        push_words(8'h40, 5);
        tick(8);
        check("t4_full_valid", 32'(m_valid), 32'd1);
        check("t4_full_no_read", 32'(fifo_read_en), 32'd0);
        check("t4_full_head", 32'(m_data), 32'h40);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_clear_invalid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        wait_valid("t4_resume", 6);
        check("t4_resume_data", 32'(m_data), 32'h42);
        tick(6);
        check("t4_all_delivered", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with one word held and one in flight.
        push_words(8'h50, 4);
        wait_valid("t5_first", 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(m_valid), 32'd0);
        check("t5_async_data", 32'(m_data), 32'd0);
        check("t5_async_read", 32'(fifo_read_en), 32'd0);
        tick(2);
        rst_n = 1'b1;
        wait_valid("t5_resume", 8);
        check("t5_resume_data", 32'(m_data), 32'h53);
        tick(4);
        check("t5_all_delivered", 32'(exp_q.size()), 32'd0);

`ifdef IOB_FIFO2STREAM_LAST_EN
        // Framing: PKT_LEN=4, last on beats 4 and 8 of 10, restart after clear.
        m_ready = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        r0 = lasts;
        m_ready = 1'b1;
        push_words(8'h60, 10);
        tick(16);
        check("t6_lasts_10", 32'(lasts - r0), 32'd2);
        m_ready = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_ready = 1'b1;
        push_words(8'h70, 4);
        tick(8);
        check("t6_lasts_after_clear", 32'(lasts - r0), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iob_fifo2stream.md
# iob_fifo2stream

Read-side adapter that drains the read port of the team's FIFOs (asynchronous FIFO read domain or synchronous FIFO) and presents the words as a valid/ready stream. It hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, so a consumer that holds ready high receives one word per cycle. It sits directly downstream of the FIFO, in the FIFO read-clock domain.

## Interface
- DATA_W, 8: word width; must equal the FIFO DATA_WIDTH.
- PKT_LEN, 16: beats per packet; used only when the last-beat feature is compiled in; must be ≥1.
- clk  in  1  FIFO read clock; all logic is on its rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- clear  in  1  synchronous flush of buffered and in-flight words (and the packet counter, when present).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after a read is issued.
- fifo_read_en  out  1  FIFO read request; asserted only when fifo_empty=0.
- m_data  out  DATA_W  stream data, registered.
- m_valid  out  1  stream valid, registered.
- m_ready  in  1  stream ready from the consumer.
- m_last  out  1  last beat of packet; present only with IOB_FIFO2STREAM_LAST_EN.

## Operation
- Buffer states: EMPTY (0 words), ONE, TWO. inflight flag = a read was issued last cycle and its word arrives this cycle.
- pop = m_valid & m_ready. occ = count + inflight - pop.
- fifo_read_en = ~fifo_empty & ~clear & (occ < 2). This is combinational from registered state, fifo_empty, m_ready and clear.
- Each cycle: count_next = occ. An arriving word is written behind any remaining word. The head is always m_data.
- Transitions: EMPTY→ONE on arrival. ONE→TWO on arrival without pop. ONE→EMPTY on pop without arrival. TWO→ONE on pop. Pop and arrival in the same cycle keep the state unchanged, with data shifted.
- TWO with no pop cannot receive an arrival; the issue rule guarantees this. Overflow is a design error; the bench checks it with an assertion.
- m_valid = (count≠0). m_data and m_valid are stable while m_valid=1 and m_ready=0.
- clear=1: count→0 and inflight→0 next cycle. A word arriving during the clear cycle is discarded. No read is issued in the clear cycle. m_valid is 0 the following cycle.
- The adapter never inspects FIFO level; only fifo_empty gates reads.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, count=0, inflight=0. fifo_read_en=0 while rst_n=0.
- Reset mid-operation discards all buffered and in-flight words immediately, asynchronously.
- Latency: fifo_empty falls in cycle N with the buffer empty. fifo_read_en=1 in N, fifo_data is valid in N+1, m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, one beat per cycle, steady state ONE with inflight=1.
- Back-pressure: after m_ready falls, at most 2 words are held. fifo_read_en drops within the same cycle once occ reaches 2.

## Configuration
- IOB_FIFO2STREAM_LAST_EN defined:
  - A beat counter of width $clog2(PKT_LEN) (minimum 1) increments on each pop and wraps from PKT_LEN-1 to 0.
  - m_last=1 on the head beat when the counter equals PKT_LEN-1.
  - The counter is reset by rst_n and by clear.
- IOB_FIFO2STREAM_LAST_EN undefined: the counter and m_last port are absent; the stream carries no framing.

## Structure
- Shared package: state encoding (EMPTY/ONE/TWO as 2-bit constants) and the buffer depth constant (2).
- One sub-module: iob_fifo2stream_buf, the 2-entry ordered buffer with push, pop, count and head output. The top level holds the issue logic, the inflight flag and the optional packet counter.

## Test plan
- Reset, then write 0x11 into an empty FIFO with m_ready=1 -> fifo_read_en pulses once, m_valid=1 with m_data=0x11 exactly 2 cycles after fifo_empty falls, then m_valid=0.
- Preload 8 words 0x00..0x07, m_ready=1 -> 8 consecutive beats in order, no bubbles after the first, exactly 8 read pulses.
- Preload 6 words, m_ready toggles 1,0,0,1 repeating -> all 6 words delivered in order, none duplicated or lost, buffer never exceeds 2, fifo_read_en=0 whenever occ=2.
- Stream running with buffer at TWO and inflight=0, clear for 1 cycle -> m_valid=0 next cycle; remaining FIFO words resume afterwards in order with no stale data.
- Assert rst_n=0 mid-stream with the buffer at ONE and inflight=1 -> m_valid=0 and m_data=0 immediately, no read issued during reset.
- With IOB_FIFO2STREAM_LAST_EN and PKT_LEN=4, stream 10 words -> m_last=1 on beats 4 and 8 only; after clear, the count restarts at beat 1.
